// File: rtl/button_conditioner.sv
// Button conditioner for the UP/DOWN game controls.
//
// Synchronizes the raw active-low push-buttons and vsync to _clk, debounces each button,
// resolves UP/DOWN conflicts (UP wins), and generates single-cycle move steps with
// frame-based auto-repeat.
//
// Ports:
//   _clk        board clock, rising-edge
//   rst         asynchronous active-high reset
//   up_btn_n    raw UP button, active-low, asynchronous
//   down_btn_n  raw DOWN button, active-low, asynchronous
//   vsync       active-high vertical sync
//   up          debounced, conflict-resolved UP level, active-low
//   down        debounced, conflict-resolved DOWN level, active-low
//   up_step     one-cycle pulse per UP move request (press and auto-repeat)
//   down_step   one-cycle pulse per DOWN move request (press and auto-repeat)
//   frame_tick  one-cycle pulse per vsync rising edge
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES     = 500000,
  parameter int unsigned REPEAT_DELAY_FRAMES = 16,
  parameter int unsigned REPEAT_RATE_FRAMES  = 4
) (
  input  logic _clk,
  input  logic rst,
  input  logic up_btn_n,
  input  logic down_btn_n,
  input  logic vsync,
  output logic up,
  output logic down,
  output logic up_step,
  output logic down_step,
  output logic frame_tick
);

  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RptMax = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ?
                                   REPEAT_DELAY_FRAMES : REPEAT_RATE_FRAMES;
  localparam int unsigned RptW   = $clog2(RptMax + 1);

  localparam logic [DbW-1:0]  DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DbW-1:0]  DbOne    = DbW'(1);
  localparam logic [RptW-1:0] RptDelay = RptW'(REPEAT_DELAY_FRAMES);
  localparam logic [RptW-1:0] RptRate  = RptW'(REPEAT_RATE_FRAMES);
  localparam logic [RptW-1:0] RptOne   = RptW'(1);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rpt_state_e;

  // Bit 0 is UP, bit 1 is DOWN throughout.
  logic [1:0] btn_meta_q, btn_sync_q;
  logic       vs_meta_q, vs_sync_q, vs_prev_q, frame_tick_q;
  logic [1:0] stable;
  logic [1:0] eff;
  logic [1:0] lvl;
  logic [1:0] step;

  // Synchronizers and vsync edge detect.
  always_ff @(posedge _clk or posedge rst) begin
    if (rst) begin
      btn_meta_q   <= 2'b11;
      btn_sync_q   <= 2'b11;
      vs_meta_q    <= 1'b0;
      vs_sync_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      btn_meta_q   <= {down_btn_n, up_btn_n};
      btn_sync_q   <= btn_meta_q;
      vs_meta_q    <= vsync;
      vs_sync_q    <= vs_meta_q;
      vs_prev_q    <= vs_sync_q;
      frame_tick_q <= vs_sync_q & ~vs_prev_q;
    end
  end

  // UP wins a conflict: DOWN reads as released whenever UP is held.
  assign eff = {stable[1] | ~stable[0], stable[0]};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic            stable_q, stable_d;
    logic [DbW-1:0]  db_cnt_q, db_cnt_d;
    logic            lvl_q;
    logic            step_q, step_d;
    rpt_state_e      state_q, state_d;
    logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;

    // Debounce: the sample must differ from the stable value for DEBOUNCE_CYCLES
    // consecutive cycles; any return to the stable value restarts the count.
    always_comb begin
      stable_d = stable_q;
      db_cnt_d = db_cnt_q;
      if (btn_sync_q[g] == stable_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DbLast) begin
        stable_d = btn_sync_q[g];
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DbOne;
      end
    end

    // Repeat FSM. lvl_q holds last cycle's effective level, so a press edge is
    // lvl_q=1 with eff=0; the step is registered alongside lvl_q so both change together.
    always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      step_d    = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (lvl_q && !eff[g]) begin
            state_d   = StDelay;
            rpt_cnt_d = RptDelay;
            step_d    = 1'b1;
          end
        end
        StDelay, StRepeat: begin
          // Release beats a coincident frame tick.
          if (eff[g]) begin
            state_d   = StIdle;
            rpt_cnt_d = '0;
          end else if (frame_tick_q) begin
            if (rpt_cnt_q == RptOne) begin
              state_d   = StRepeat;
              rpt_cnt_d = RptRate;
              step_d    = 1'b1;
            end else begin
              rpt_cnt_d = rpt_cnt_q - RptOne;
            end
          end
        end
        default: begin
          state_d   = StIdle;
          rpt_cnt_d = '0;
        end
      endcase
    end

    always_ff @(posedge _clk or posedge rst) begin
      if (rst) begin
        stable_q  <= 1'b1;
        db_cnt_q  <= '0;
        lvl_q     <= 1'b1;
        step_q    <= 1'b0;
        state_q   <= StIdle;
        rpt_cnt_q <= '0;
      end else begin
        stable_q  <= stable_d;
        db_cnt_q  <= db_cnt_d;
        lvl_q     <= eff[g];
        step_q    <= step_d;
        state_q   <= state_d;
        rpt_cnt_q <= rpt_cnt_d;
      end
    end

    assign stable[g] = stable_q;
    assign lvl[g]    = lvl_q;
    assign step[g]   = step_q;
  end

  assign up         = lvl[0];
  assign down       = lvl[1];
  assign up_step    = step[0];
  assign down_step  = step[1];
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner with
// DEBOUNCE_CYCLES=8, REPEAT_DELAY_FRAMES=3, REPEAT_RATE_FRAMES=2.
module tb_button_conditioner;

  logic clk;
  logic rst;
  logic up_btn_n, down_btn_n, vsync;
  logic up, down, up_step, down_step, frame_tick;

  int checks;
  int errors;
  int up_steps;
  int down_steps;
  int both_steps;
  int base;
  int dbase;
  logic seen_low;

  button_conditioner #(
    .DEBOUNCE_CYCLES    (8),
    .REPEAT_DELAY_FRAMES(3),
    .REPEAT_RATE_FRAMES (2)
  ) dut (
    ._clk      (clk),
    .rst       (rst),
    .up_btn_n  (up_btn_n),
    .down_btn_n(down_btn_n),
    .vsync     (vsync),
    .up        (up),
    .down      (down),
    .up_step   (up_step),
    .down_step (down_step),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled on the inactive edge.
  initial begin
    up_steps   = 0;
    down_steps = 0;
    both_steps = 0;
  end
  always @(negedge clk) begin
    if (up_step) up_steps <= up_steps + 1;
    if (down_step) down_steps <= down_steps + 1;
    if (up_step && down_step) both_steps <= both_steps + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges; leaves time at 1 unit after the last edge.
  task automatic step_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    step_clk(2);
    vsync = 1'b0;
    step_clk(4);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    up_btn_n   = 1'b1;
    down_btn_n = 1'b1;
    vsync      = 1'b0;
    step_clk(3);
    check("reset_up", up, 1);
    check("reset_down", down, 1);
    check("reset_up_step", up_step, 0);
    check("reset_down_step", down_step, 0);
    check("reset_frame_tick", frame_tick, 0);
    rst = 1'b0;
    step_clk(3);

    // 7-cycle glitch must not be accepted.
    up_btn_n = 1'b0;
    step_clk(7);
    up_btn_n = 1'b1;
    seen_low = 1'b0;
    repeat (15) begin
      step_clk(1);
      if (!up) seen_low = 1'b1;
    end
    check("glitch_up_stays_high", seen_low, 0);
    check("glitch_no_up_step", up_steps, 0);

    // Real press: up falls with one step 11 cycles after the drive.
    base     = up_steps;
    up_btn_n = 1'b0;
    step_clk(10);
    check("press_up_c10", up, 1);
    check("press_step_c10", up_step, 0);
    step_clk(1);
    check("press_up_c11", up, 0);
    check("press_step_c11", up_step, 1);
    step_clk(1);
    check("press_step_c12", up_step, 0);
    step_clk(8);
    check("press_one_step", up_steps - base, 1);

    // frame_tick latency 3, width 1.
    vsync = 1'b1;
    step_clk(2);
    check("tick_c2", frame_tick, 0);
    step_clk(1);
    check("tick_c3", frame_tick, 1);
    vsync = 1'b0;
    step_clk(1);
    check("tick_c4", frame_tick, 0);
    step_clk(3);

    // Auto-repeat: ticks 3,5,7,9 add steps.
    vsync_pulse();
    vsync_pulse();
    check("repeat_after_3_ticks", up_steps - base, 2);
    repeat (6) vsync_pulse();
    check("repeat_after_9_ticks", up_steps - base, 5);

    // Conflict: UP wins, DOWN unmasked on UP release.
    base       = up_steps;
    dbase      = down_steps;
    down_btn_n = 1'b0;
    step_clk(20);
    check("both_up_low", up, 0);
    check("both_down_masked", down, 1);
    check("both_no_down_step", down_steps - dbase, 0);
    up_btn_n = 1'b1;
    step_clk(10);
    check("unmask_down_c10", down, 1);
    step_clk(1);
    check("unmask_down_c11", down, 0);
    check("unmask_dstep_c11", down_step, 1);
    check("unmask_up_c11", up, 1);
    step_clk(3);
    check("unmask_one_dstep", down_steps - dbase, 1);
    check("release_no_up_step", up_steps - base, 0);
    down_btn_n = 1'b1;
    step_clk(15);
    check("down_released", down, 1);

    // Release coincident with the expiring frame tick.
    base     = up_steps;
    up_btn_n = 1'b0;
    step_clk(14);
    check("race_pressed", up, 0);
    vsync_pulse();
    vsync_pulse();
    check("race_pre_steps", up_steps - base, 1);
    up_btn_n = 1'b1;
    step_clk(7);
    vsync = 1'b1;
    step_clk(3);
    check("race_tick_present", frame_tick, 1);
    check("race_up_still_low", up, 0);
    step_clk(1);
    vsync = 1'b0;
    check("race_up_released", up, 1);
    check("race_no_step", up_step, 0);
    step_clk(4);
    vsync_pulse();
    vsync_pulse();
    check("race_steps_total", up_steps - base, 1);
    // FSM back in IDLE: a new press steps immediately.
    up_btn_n = 1'b0;
    step_clk(11);
    check("repress_step", up_step, 1);
    up_btn_n = 1'b1;
    step_clk(15);

    // Reset while DOWN is auto-repeating.
    dbase      = down_steps;
    down_btn_n = 1'b0;
    step_clk(14);
    vsync_pulse();
    vsync_pulse();
    vsync_pulse();
    check("pre_rst_dsteps", down_steps - dbase, 2);
    check("pre_rst_down", down, 0);
    rst = 1'b1;
    #2;
    check("rst_async_down", down, 1);
    check("rst_async_up", up, 1);
    check("rst_async_dstep", down_step, 0);
    check("rst_async_tick", frame_tick, 0);
    step_clk(3);
    rst   = 1'b0;
    dbase = down_steps;
    step_clk(10);
    check("post_rst_down_c10", down, 1);
    step_clk(1);
    check("post_rst_down_c11", down, 0);
    check("post_rst_dstep_c11", down_step, 1);
    step_clk(1);
    check("post_rst_dstep_c12", down_step, 0);
    step_clk(5);
    check("post_rst_one_dstep", down_steps - dbase, 1);

    check("never_both_steps", both_steps, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive _clk cycles a raw level must hold before it is accepted (10 ms at 50 MHz).
REQ-002 Parameter REPEAT_DELAY_FRAMES, default 16, is the number of frame ticks from a press to the first auto-repeat step.
REQ-003 Parameter REPEAT_RATE_FRAMES, default 4, is the number of frame ticks between subsequent auto-repeat steps.
REQ-004 _clk  input  1  50 MHz board clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high; clock _clk.
REQ-006 up_btn_n  input  1  raw UP push-button, active-low, asynchronous to _clk.
REQ-007 down_btn_n  input  1  raw DOWN push-button, active-low, asynchronous to _clk.
REQ-008 vsync  input  1  active-high vertical sync from the VGA timing stage.
REQ-009 up  output  1  debounced, conflict-resolved UP level, active-low; drop-in replacement for the raw button at the game core.
REQ-010 down  output  1  debounced, conflict-resolved DOWN level, active-low.
REQ-011 up_step  output  1  single-_clk-cycle pulse per UP move request, including auto-repeat.
REQ-012 down_step  output  1  single-_clk-cycle pulse per DOWN move request, including auto-repeat.
REQ-013 frame_tick  output  1  single-_clk-cycle pulse on each vsync rising edge.

Function
REQ-014 up_btn_n, down_btn_n and vsync shall each pass through a 2-flop synchronizer; the button synchronizers reset to 1 and the vsync synchronizer resets to 0.
REQ-015 frame_tick shall assert for exactly one cycle when the synchronized vsync is 1 and its previous registered value is 0; frame_tick latency is 3 cycles from the raw vsync rise.
REQ-016 Each button shall have a stable register (reset 1) and a counter of width $clog2(DEBOUNCE_CYCLES+1) (reset 0).
REQ-017 When the synchronized sample equals the stable value, the counter shall clear to 0.
REQ-018 When the sample differs and counter == DEBOUNCE_CYCLES-1, the stable register shall take the sample and the counter shall clear; otherwise the counter shall increment.
REQ-019 Any sample glitch shorter than DEBOUNCE_CYCLES shall leave the stable register unchanged and restart the count.
REQ-020 Conflict: when both stable values are 0, UP shall win; the effective DOWN press shall be masked to released (down=1) while UP is held.
REQ-021 up and down shall be registered copies of the effective (post-conflict) levels.
REQ-022 Each button shall have an independent repeat FSM with states IDLE, DELAY and REPEAT, and a frame counter of width $clog2(max(REPEAT_DELAY_FRAMES,REPEAT_RATE_FRAMES)+1).
REQ-023 IDLE -> DELAY on an effective press edge (1->0); the step output shall pulse in that same cycle, and the counter shall load REPEAT_DELAY_FRAMES.
REQ-024 In DELAY or REPEAT, each frame_tick shall decrement the counter.
REQ-025 When a frame_tick arrives with counter == 1, the step output shall pulse, the counter shall load REPEAT_RATE_FRAMES, and the FSM shall enter REPEAT.
REQ-026 An effective release in any state shall return the FSM to IDLE with counter 0 and no step pulse; release takes precedence over a coincident frame_tick.
REQ-027 A DOWN press masked by UP shall produce a DOWN press edge when UP releases, if DOWN is still held.
REQ-028 At most one step pulse per button per cycle; up_step and down_step shall never assert in the same cycle.
REQ-029 Press-to-up/down latency shall be 2 (sync) + DEBOUNCE_CYCLES + 1 cycles; step pulses shall coincide with the up/down edge.

Reset
REQ-030 While rst=1: up=1, down=1, up_step=0, down_step=0, frame_tick=0, all FSMs in IDLE, all counters 0; outputs take these values asynchronously on rst rise.
REQ-031 Reset asserted mid-debounce or mid-repeat shall discard all progress; after release, a held button shall be re-debounced from zero.

Verification (DEBOUNCE_CYCLES=8, REPEAT_DELAY_FRAMES=3, REPEAT_RATE_FRAMES=2)
REQ-032 Drive up_btn_n 0 for 7 cycles, then 1 -> up stays 1, no up_step; hold 0 for 20 cycles -> up falls and up_step pulses exactly once, 11 cycles after the drive.
REQ-033 Hold UP, issue 9 vsync pulses -> up_step count = 1 (press) + 1 (tick 3) + 3 (ticks 5, 7, 9) = 5.
REQ-034 Hold both buttons -> up=0, down=1, only up_step pulses; release UP (debounced) -> down falls and down_step pulses once.
REQ-035 Release UP on the same cycle a frame_tick would expire the counter -> no up_step; FSM returns to IDLE.
REQ-036 Assert rst while holding DOWN in REPEAT -> all outputs return to reset values immediately; after deassert, down falls again 11 cycles later with one down_step.
